pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Elastic pipeline stage that sits between two stages of the pipelined RISC-V core, on the consuming end of the stage-register interface. It accepts one N-bit word per cycle from an upstream producer over a valid/ready handshake, holds up to two words (main + skid) so backpressure never creates a combinational ready path, and presents words in order to the downstream stage. It also supports a synchronous flush for branch/jump redirects and a saturating stall-cycle counter for performance debug.

## Interface
- N, 32, data width in bits
- CNT_W, 16, width of the stall counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- flush  input  1  synchronous discard of all held and incoming words
- in_valid  input  1  upstream word present
- in_data  input  N  upstream word
- in_ready  output  1  stage can accept a word this cycle
- out_valid  output  1  word present on out_data
- out_data  output  N  oldest held word
- out_ready  input  1  downstream takes out_data this cycle
- occupancy  output  2  number of held words (0, 1, 2)
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1, out_ready=0

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- States: EMPTY (0 words), ONE (main valid), TWO (main + skid valid).
- in_ready = (state != TWO); out_valid = (state != EMPTY); out_data = main register; occupancy encodes state.
- EMPTY: in transfer -> main <= in_data, go ONE; else stay.
- ONE: in & out -> main <= in_data, stay ONE; in only -> skid <= in_data, go TWO; out only -> go EMPTY; neither -> stay.
- TWO: out transfer -> main <= skid, go ONE; else stay (no in transfer possible).
- flush=1: highest priority; next state EMPTY regardless of handshakes; any word accepted that edge is discarded; an out transfer that edge still counts as delivered to downstream.
- Order is strictly FIFO; no word duplicated or lost except by flush.
- stall_cnt increments when out_valid=1 & out_ready=0, saturates at 2^CNT_W-1, not cleared by flush; cleared only by reset.
- Data registers hold value when not loaded; their contents when invalid are don't-care but must not be X after reset.

## Timing
- Reset (rst=0, asynchronous): state EMPTY, in_ready=1, out_valid=0, out_data=0, occupancy=0, stall_cnt=0. Deassertion takes effect at the next edge.
- Latency: word accepted at edge t appears on out_data with out_valid=1 after edge t (visible cycle t+1).
- Throughput: one word/cycle sustained when out_ready=1.
- in_ready, out_valid, out_data, occupancy depend only on registered state: no combinational path from in_* or out_ready to any output.
- Backpressure: after out_ready drops, at most one more word is accepted (into skid), then in_ready=0 from next cycle.
- Reset asserted mid-transfer: held words discarded immediately, outputs return to reset values asynchronously.

## Structure
- Shared package pipe_pkg: state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2 (equal to occupancy value).
- One sub-module: skid_data_reg, an N-bit load-enabled register with async active-low reset, instantiated twice (main, skid).
- Control FSM and counter in the top module.

## Test plan
- Reset: rst=0 mid-stream with 2 words held -> immediately out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on following consecutive cycles, occupancy stays 1.
- Backpressure: hold out_ready=0, push 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, in_ready=0 with 0xA3 pending, occupancy=2; raise out_ready -> 0xA1, 0xA2, 0xA3 delivered in order, none lost.
- Flush: occupancy=2 and in_valid=1 with flush=1 -> next cycle occupancy=0, out_valid=0, flushed words never appear.
- Simultaneous in & out in ONE: main=0x5, push 0x6 with out_ready=1 -> 0x5 delivered, out_data=0x6, occupancy=1.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, unchanged by flush.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding for the elastic pipeline stage
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/skid_data_reg.sv
// skid_data_reg: load-enabled data register with async active-low reset
module skid_data_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry elastic stage with flush and saturating stall counter
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  state_t state, nxt;
  logic in_xfer, out_xfer, main_ld, skid_ld;
  logic [N-1:0] main_d, skid_q;
  assign in_ready  = state != ST_TWO;
  assign out_valid = state != ST_EMPTY;
  assign occupancy = state;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // main refills from skid when draining TWO, otherwise straight from upstream
  assign main_ld = state == ST_TWO ? out_xfer : in_xfer && (state == ST_EMPTY || out_xfer);
  assign skid_ld = in_xfer && state == ST_ONE && !out_xfer;
  assign main_d  = state == ST_TWO ? skid_q : in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_EMPTY;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = flush ? ST_EMPTY :
          state == ST_EMPTY ? (in_xfer ? ST_ONE : ST_EMPTY) :
          state == ST_ONE ? (in_xfer && !out_xfer ? ST_TWO : !in_xfer && out_xfer ? ST_EMPTY : ST_ONE) :
          (out_xfer ? ST_ONE : ST_TWO);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  skid_data_reg #(.N(N)) u_main (.clk(clk), .rst(rst), .load(main_ld), .d(main_d), .q(out_data));
  skid_data_reg #(.N(N)) u_skid (.clk(clk), .rst(rst), .load(skid_ld), .d(in_data), .q(skid_q));
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench with a queue-based reference model
module tb_pipe_skid_stage;
  localparam int N = 32;
  localparam int CNT_W = 4;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic in_valid = 0;
  logic [N-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic [N-1:0] out_data;
  logic out_ready = 0;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] stall_cnt;
  int errors = 0;
  int checks = 0;
  logic [N-1:0] q[$];
  int cnt = 0;
  int sc = 0;
  bit acc, dlv;

  pipe_skid_stage #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a FIFO of capacity two, updated at each clock edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      cnt = 0;
      sc = 0;
    end else begin
      acc = in_valid && cnt < 2;
      dlv = out_ready && cnt > 0;
      if (cnt > 0 && !out_ready && sc < SAT) sc++;
      if (flush) begin
        cnt = 0;
        q.delete();
      end else begin
        cnt = cnt - int'(dlv) + int'(acc);
        if (acc) q.push_back(in_data);
      end
    end
  end

  // monitor: checks status and pops the scoreboard on each outgoing transfer
  always @(negedge clk) if (rst) begin
    chk("occupancy", N'(occupancy), N'(cnt));
    chk("in_ready", N'(in_ready), N'(cnt < 2));
    chk("out_valid", N'(out_valid), N'(cnt > 0));
    chk("stall_cnt", N'(stall_cnt), N'(sc));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_data: got %0h expected no word at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, q[0]);
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(0, 0, 0, 0);
    chk("rst_in_ready", N'(in_ready), 1);
    chk("rst_out_valid", N'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", N'(occupancy), 0);
    chk("rst_stall_cnt", N'(stall_cnt), 0);
    rst = 1;
    step(1, 32'h11, 1, 0);
    step(1, 32'h22, 1, 0);
    step(1, 32'h33, 1, 0);
    chk("stream_occ", N'(occupancy), 1);
    chk("stream_data", out_data, 32'h33);
    step(0, 0, 1, 0);
    step(1, 32'hA1, 0, 0);
    step(1, 32'hA2, 0, 0);
    chk("bp_occ", N'(occupancy), 2);
    chk("bp_in_ready", N'(in_ready), 0);
    step(1, 32'hA3, 0, 0);
    chk("bp_hold_occ", N'(occupancy), 2);
    chk("bp_hold_data", out_data, 32'hA1);
    step(1, 32'hA3, 1, 0);
    chk("bp_drain1", out_data, 32'hA2);
    step(1, 32'hA3, 1, 0);
    chk("bp_drain2", out_data, 32'hA3);
    step(0, 0, 1, 0);
    chk("bp_empty", N'(occupancy), 0);
    step(1, 32'hB1, 0, 0);
    step(1, 32'hB2, 0, 0);
    step(1, 32'hB3, 0, 1);
    chk("flush_occ", N'(occupancy), 0);
    chk("flush_valid", N'(out_valid), 0);
    step(0, 0, 1, 0);
    chk("flush_stays_empty", N'(out_valid), 0);
    step(1, 32'h5, 0, 0);
    chk("sim_main", out_data, 32'h5);
    step(1, 32'h6, 1, 0);
    chk("sim_data", out_data, 32'h6);
    chk("sim_occ", N'(occupancy), 1);
    step(0, 0, 1, 0);
    step(1, 32'h77, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    chk("sat_cnt", N'(stall_cnt), SAT);
    step(0, 0, 0, 1);
    chk("sat_after_flush", N'(stall_cnt), SAT);
    step(1, 32'hC1, 0, 0);
    step(1, 32'hC2, 0, 0);
    chk("pre_rst_occ", N'(occupancy), 2);
    rst = 0;
    #1;
    chk("arst_out_valid", N'(out_valid), 0);
    chk("arst_in_ready", N'(in_ready), 1);
    chk("arst_occ", N'(occupancy), 0);
    chk("arst_stall_cnt", N'(stall_cnt), 0);
    chk("arst_out_data", out_data, 0);
    step(0, 0, 0, 0);
    rst = 1;
    for (int i = 0; i < 1500; i++)
      step($urandom % 4 != 0, $urandom, $urandom % 3 != 0, $urandom % 40 == 0);
    step(0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
